mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single-ported, 4-cycle-latency main memory between the I-cache miss handler and the D-cache miss/write-through handler. Sequences 8-word block fills (pipelined issue, in-order return) and single-word writes, and steers returned data to the granted requester. It sits between the two cache controllers in the fetch and memory phases and the main memory model. While a requester waits, its controller holds its pipeline stall.

## Interface
- WORDS, 8: 16-bit words per cache block (2 bytes each, block = 16 bytes)
- MEM_LAT, 4: cycles from a memory issue to its mem_valid

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- i_req  in  1  I-cache block-fill request (read only)
- i_addr  in  16  I-side byte address; bits [3:0] ignored
- i_grant  out  1  I-side owns memory
- i_data  out  16  returned word for I-side
- i_valid  out  1  i_data/i_word valid this cycle
- i_word  out  3  word index within block of i_data
- i_done  out  1  I-side transfer complete (1-cycle pulse)
- d_req  in  1  D-side request
- d_wr  in  1  1 = single-word write, 0 = block fill
- d_addr  in  16  D-side byte address; fill ignores [3:0], write ignores [0]
- d_wdata  in  16  write data
- d_grant, d_data, d_valid, d_word, d_done  out  1/16/1/3/1  D-side equivalents of I-side outputs
- mem_addr  out  16  memory byte address
- mem_enable  out  1  memory issue strobe
- mem_wr  out  1  1 = write issue
- mem_wdata  out  16  memory write data
- mem_data  in  16  memory read data
- mem_valid  in  1  mem_data valid (MEM_LAT cycles after each read issue, in order)

## Operation
- States: IDLE, READ (issuing + draining), WRITE.
- IDLE: sample i_req/d_req. Single request: grant it. Both: grant the side not granted last (last_grant register). Reset sets last_grant = I, so D wins the first tie. Requests are latched at grant: address, d_wr, d_wdata.
- Requests are only evaluated in IDLE. A requester holding req in any other state waits.
- READ: base = addr & 16'hFFF0.
  - Issue counter k = 0..7 issues mem_addr = base + 2k with mem_enable=1, mem_wr=0 on 8 consecutive cycles.
  - A separate 3-bit return counter r counts mem_valid. Each valid drives the granted side: data = mem_data, valid = 1, word = r.
  - done asserts together with the 8th valid (r = 7). The next state is IDLE.
  - base + 14 never overflows (0xFFF0 -> last issue 0xFFFE).
- WRITE: one cycle with mem_enable=1, mem_wr=1, mem_addr = d_addr & 16'hFFFE, mem_wdata = latched d_wdata, d_done=1. The next state is IDLE.
- Grant is high from the first issue cycle through the done cycle inclusive. It is never high for both sides at once.
- Requester rule: drop req in the cycle after done. A req still high in IDLE starts a new transfer.
- Ungranted side: data/valid/word/done outputs are 0.
- mem_valid outside READ is ignored: no output, no counter change.
- Outputs are 0 in IDLE except grant transitions. mem_addr/mem_wdata are 0 when mem_enable=0.

## Timing
- Reset (rst=0 at a clock edge): state IDLE, counters 0, last_grant = I. All outputs 0 from the following cycle.
- Reset mid-burst abandons the transfer with no done. Stale mem_valid pulses after reset are ignored (state IDLE).
- Read, req seen in IDLE at cycle 0:
  - grant and issue k=0 at cycle 1, issues at cycles 1–8.
  - valid for word k at cycle 1+k+MEM_LAT (5–12).
  - done at cycle 12, IDLE at cycle 13.
  - Back-to-back fills: new grant at cycle 14 at earliest.
- Write, req at cycle 0: grant + memory write + done at cycle 1, IDLE at cycle 2.
- Exactly 8 mem_enable read issues and exactly 8 valids per fill. No issues in the done cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with i_req=d_req=1 → all outputs 0, no mem_enable. Release → d_grant=1 the next cycle (tie goes to D).
- I fill at i_addr=16'h1237: mem_addr 0x1230,0x1232,…,0x123E at cycles 1–8. Memory returns 0xA000+k → i_valid at cycles 5–12 with i_word=k and i_data=0xA000+k. i_done at cycle 12 only. d_* outputs stay 0.
- Simultaneous i_req and d_req (fill) held: D fill completes, then I fill is granted at its next IDLE. Then a D/I tie goes to D again (alternation verified over 4 transfers).
- D write d_addr=16'h00FF, d_wdata=16'hBEEF: one cycle with mem_enable=1, mem_wr=1, mem_addr=0x00FE, mem_wdata=0xBEEF, d_done=1. IDLE next cycle.
- Wrap boundary: fill at 16'hFFF9 → last issue 0xFFFE, no address past 0xFFFE, 8 valids.
- rst=0 at cycle 6 of an I fill: no i_done. Pending mem_valid pulses at cycles 7–12 produce no i_valid. A new d_req after release gets a normal fill.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single-ported main memory between the I-cache and D-cache miss handlers:
// 8-word pipelined block fills, single-word D writes, return data steered to the owner.
module mem_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req_i,
    input  logic [15:0] i_addr_i,
    output logic        i_grant_o,
    output logic [15:0] i_data_o,
    output logic        i_valid_o,
    output logic [2:0]  i_word_o,
    output logic        i_done_o,
    input  logic        d_req_i,
    input  logic        d_wr_i,
    input  logic [15:0] d_addr_i,
    input  logic [15:0] d_wdata_i,
    output logic        d_grant_o,
    output logic [15:0] d_data_o,
    output logic        d_valid_o,
    output logic [2:0]  d_word_o,
    output logic        d_done_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_enable_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_data_i,
    input  logic        mem_valid_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q;
    logic        grant_i_q, grant_d_q;
    logic        last_d_q;
    logic [11:0] base_q;
    logic [2:0]  issue_cnt_q;
    logic [2:0]  ret_cnt_q;
    logic        mem_en_q, mem_wr_q;
    logic [15:0] mem_addr_q, mem_wdata_q;

    logic        pick_d;
    logic [11:0] pick_base;
    logic        rd_valid;
    logic        unused_addr_bits;

    // Tie goes to whichever side did not own the previous transfer.
    assign pick_d    = d_req_i && (!i_req_i || !last_d_q);
    assign pick_base = pick_d ? d_addr_i[15:4] : i_addr_i[15:4];
    assign unused_addr_bits = ^{i_addr_i[3:0], d_addr_i[0]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_i_q   <= 1'b0;
            grant_d_q   <= 1'b0;
            last_d_q    <= 1'b0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_i || d_req_i) begin
                        grant_i_q <= !pick_d;
                        grant_d_q <= pick_d;
                        last_d_q  <= pick_d;
                        mem_en_q  <= 1'b1;
                        if (pick_d && d_wr_i) begin
                            state_q     <= WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= {d_addr_i[15:1], 1'b0};
                            mem_wdata_q <= d_wdata_i;
                        end else begin
                            state_q     <= READ;
                            base_q      <= pick_base;
                            mem_addr_q  <= {pick_base, 4'h0};
                            issue_cnt_q <= 3'd1;
                            ret_cnt_q   <= 3'd0;
                        end
                    end
                end
                READ: begin
                    // issue_cnt_q wraps to 0 once word 7 is on the bus: stop issuing.
                    if (mem_en_q) begin
                        if (issue_cnt_q == 3'd0) begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end else begin
                            mem_addr_q  <= {base_q, issue_cnt_q, 1'b0};
                            issue_cnt_q <= issue_cnt_q + 3'd1;
                        end
                    end
                    if (mem_valid_i) begin
                        ret_cnt_q <= ret_cnt_q + 3'd1;
                        if (ret_cnt_q == 3'd7) begin
                            state_q   <= IDLE;
                            grant_i_q <= 1'b0;
                            grant_d_q <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    grant_i_q   <= 1'b0;
                    grant_d_q   <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Return data passes straight through in the cycle memory presents it.
    assign rd_valid = (state_q == READ) && mem_valid_i;

    assign i_grant_o = grant_i_q;
    assign i_valid_o = rd_valid && grant_i_q;
    assign i_data_o  = i_valid_o ? mem_data_i : 16'h0;
    assign i_word_o  = i_valid_o ? ret_cnt_q : 3'd0;
    assign i_done_o  = i_valid_o && (ret_cnt_q == 3'd7);

    assign d_grant_o = grant_d_q;
    assign d_valid_o = rd_valid && grant_d_q;
    assign d_data_o  = d_valid_o ? mem_data_i : 16'h0;
    assign d_word_o  = d_valid_o ? ret_cnt_q : 3'd0;
    assign d_done_o  = (d_valid_o && (ret_cnt_q == 3'd7)) || (state_q == WRITE);

    assign mem_enable_o = mem_en_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
